// File: rtl/pe_row_sched.sv
// rtl/pe_row_sched.sv - weight-stationary 8-PE row sequencer: weight load, input skew, result realignment
module pe_row_sched #(
    parameter int WEIGHT_BW      = 8,
    parameter int DATA_BW        = 8,
    parameter int PARTIAL_SUM_BW = 19,
    parameter int MATRIX_SIZE    = 8,
    parameter int RESULT_LAT     = MATRIX_SIZE,
    parameter int CNT_BW         = 8
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               start,
    input  logic [CNT_BW-1:0]                  num_vec,
    input  logic [MATRIX_SIZE*WEIGHT_BW-1:0]   w_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [MATRIX_SIZE*DATA_BW-1:0]     in_data,
    output logic                               we_rl,
    output logic [MATRIX_SIZE*WEIGHT_BW-1:0]   weights,
    output logic [MATRIX_SIZE*DATA_BW-1:0]     din,
    input  logic [PARTIAL_SUM_BW-1:0]          result,
    output logic                               out_valid,
    output logic [PARTIAL_SUM_BW-1:0]          out_data,
    output logic                               busy,
    output logic                               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    state_t                nxt_state;
    logic [CNT_BW-1:0]     rem_cnt;
    logic [RESULT_LAT:0]   tag_pipe;
    logic                  accept;
    logic                  job_start;

    assign accept    = in_valid & in_ready;
    assign job_start = (state == S_IDLE) && start;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next-state logic; DRAIN waits until the last tagged vector has left the tag pipe
    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE:   if (start) nxt_state = S_LOAD_W;
            S_LOAD_W: nxt_state = (rem_cnt == '0) ? S_DONE : S_STREAM;
            S_STREAM: if (accept && (rem_cnt == CNT_BW'(1))) nxt_state = S_DRAIN;
            S_DRAIN:  if (tag_pipe == '0) nxt_state = S_DONE;
            S_DONE:   nxt_state = S_IDLE;
            default:  nxt_state = S_IDLE;
        endcase
    end

    // Output decode; in_ready is forced low once the job's vectors are all taken
    always_comb begin
        in_ready = (state == S_STREAM) && (rem_cnt != '0);
        we_rl    = (state == S_LOAD_W);
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
    end

    // Job parameters: weights and remaining-vector count captured on an accepted start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weights <= '0;
            rem_cnt <= '0;
        end else if (job_start) begin
            weights <= w_in;
            rem_cnt <= num_vec;
        end else if (accept) begin
            rem_cnt <= rem_cnt - CNT_BW'(1);
        end
    end

    // Tag pipe: marks real vectors, aligned to lane-0 timing plus the chain latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe <= {tag_pipe[RESULT_LAT-1:0], accept};
        end
    end

    assign out_valid = tag_pipe[RESULT_LAT];
    assign out_data  = out_valid ? result : '0;

    // Diagonal skew: lane k passes through 1+k registers; bubbles shift in zeros
    for (genvar k = 0; k < MATRIX_SIZE; k++) begin : g_lane
        logic [DATA_BW-1:0] stage [0:k];
        logic [DATA_BW-1:0] lane_in;

        assign lane_in = accept ? in_data[(MATRIX_SIZE-1-k)*DATA_BW +: DATA_BW] : '0;

        // Lane shift register
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int j = 0; j <= k; j++) stage[j] <= '0;
            end else begin
                stage[0] <= lane_in;
                for (int j = 1; j <= k; j++) stage[j] <= stage[j-1];
            end
        end

        assign din[(MATRIX_SIZE-1-k)*DATA_BW +: DATA_BW] = stage[k];
    end

endmodule

// File: tb/tb_pe_row_sched.sv
// tb/tb_pe_row_sched.sv - directed self-checking bench for pe_row_sched with a behavioural PE row
module tb_pe_row_sched;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_vec = '0;
    logic [63:0] w_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        we_rl;
    logic [63:0] weights;
    logic [63:0] din;
    logic [18:0] result = '0;
    logic        out_valid;
    logic [18:0] out_data;
    logic        busy;
    logic        done;

    pe_row_sched dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .num_vec   (num_vec),
        .w_in      (w_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .we_rl     (we_rl),
        .weights   (weights),
        .din       (din),
        .result    (result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_cnt, we_cnt, done_cnt, done_cyc, gate_bad, busy_bad;
    int ov_cyc[$];
    longint ov_dat[$];
    logic [63:0] din_log [int];

    // Behavioural row: latches weights on we_rl, lane k result term uses din from 7-k cycles back
    logic [63:0] hist [0:7] = '{default: '0};
    logic [63:0] row_w = '0;
    always @(negedge clk) begin : row_model
        int acc;
        if (we_rl) row_w = weights;
        for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = din;
        acc = 0;
        for (int k = 0; k < 8; k++)
            acc += int'($signed(row_w[(7-k)*8 +: 8])) * int'($signed(hist[7-k][(7-k)*8 +: 8]));
        result = 19'(acc);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input logic [63:0] v, input int k);
        logic [7:0] b;
        b = v[(7-k)*8 +: 8];
        return longint'($signed(b));
    endfunction

    task automatic clear_logs();
        ov_cyc.delete();
        ov_dat.delete();
        rdy_cnt = 0; we_cnt = 0; done_cnt = 0; done_cyc = -1; gate_bad = 0; busy_bad = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        din_log[cyc] = din;
        if (in_ready) rdy_cnt++;
        if (we_rl) we_cnt++;
        if (out_valid) begin
            ov_cyc.push_back(cyc);
            ov_dat.push_back(longint'($signed(out_data)));
        end else if (out_data != '0) begin
            gate_bad++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (!busy) busy_bad++;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic single_job(input string tag, input logic [63:0] w, input logic [63:0] d,
                              input longint exp, input bit hold_start);
        int t;
        clear_logs();
        start = 1'b1; num_vec = 8'd1; w_in = w; in_valid = 1'b0; in_data = d;
        step();
        check({tag, "_we"}, we_rl, 1);
        check({tag, "_load_din"}, din, 0);
        check({tag, "_wcap"}, weights, w);
        start = hold_start; w_in = hold_start ? ~w : w; in_valid = 1'b1;
        step();
        t = cyc;
        check({tag, "_rdy"}, in_ready, 1);
        step();
        check({tag, "_drain_rdy"}, in_ready, 0);
        in_valid = 1'b0;
        wait_done(40);
        start = 1'b0;
        check({tag, "_beats"}, ov_cyc.size(), 1);
        if (ov_cyc.size() > 0) begin
            check({tag, "_lat"}, ov_cyc[0], t + 9);
            check({tag, "_data"}, ov_dat[0], exp);
        end
        check({tag, "_done_cyc"}, done_cyc, t + 11);
        check({tag, "_we_cnt"}, we_cnt, 1);
        check({tag, "_busy_at_done"}, busy_bad, 0);
        check({tag, "_gate"}, gate_bad, 0);
        step();
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_after"}, done, 0);
        check({tag, "_whold"}, weights, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        // Reset state
        #1 rstn = 1'b0;
        #2;
        check("rst_we", we_rl, 0);
        check("rst_rdy", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ov", out_valid, 0);
        check("rst_od", out_data, 0);
        check("rst_w", weights, 0);
        check("rst_din", din, 0);
        repeat (3) step();
        rstn = 1'b1;

        // Idle with in_valid high: nothing accepted
        clear_logs();
        in_valid = 1'b1;
        repeat (10) step();
        check("idle_rdy", rdy_cnt, 0);
        check("idle_ov", ov_cyc.size(), 0);
        check("idle_busy", busy, 0);
        in_valid = 1'b0;

        // Single vector
        single_job("single", {8{8'd1}}, {8{8'd2}}, 16, 1'b0);

        // Skew and signed values, three back-to-back vectors
        clear_logs();
        start = 1'b1; num_vec = 8'd3;
        w_in = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        step();
        start = 1'b0; in_valid = 1'b1;
        step();
        t0 = cyc;
        in_data = {8{8'h01}};
        step();
        in_data = {8{8'hFF}};
        step();
        in_data = {8{8'h80}};
        check("skew_rdy3", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("skew_drain_rdy", in_ready, 0);
        wait_done(40);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("skew_pre_l%0d", k), lane(din_log[t0 + k], k), 0);
            check($sformatf("skew_v0_l%0d", k), lane(din_log[t0 + 1 + k], k), 1);
            check($sformatf("skew_v1_l%0d", k), lane(din_log[t0 + 2 + k], k), -1);
            check($sformatf("skew_v2_l%0d", k), lane(din_log[t0 + 3 + k], k), -128);
        end
        check("skew_beats", ov_cyc.size(), 3);
        if (ov_cyc.size() == 3) begin
            check("skew_lat0", ov_cyc[0], t0 + 9);
            check("skew_lat1", ov_cyc[1], t0 + 10);
            check("skew_lat2", ov_cyc[2], t0 + 11);
            check("skew_d0", ov_dat[0], 36);
            check("skew_d1", ov_dat[1], -36);
            check("skew_d2", ov_dat[2], -4608);
        end
        check("skew_gate", gate_bad, 0);
        step();

        // Bubbles: valid every other cycle, four vectors
        clear_logs();
        start = 1'b1; num_vec = 8'd4; w_in = {8{8'd1}};
        step();
        start = 1'b0;
        t0 = 0;
        for (int j = 0; j < 12; j++) begin
            step();
            if (j == 0) t0 = cyc;
            in_valid = (j % 2 == 0);
            in_data = {8{8'(j / 2 + 1)}};
        end
        in_valid = 1'b0;
        wait_done(40);
        check("bub_rdy_cycles", rdy_cnt, 7);
        check("bub_beats", ov_cyc.size(), 4);
        if (ov_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("bub_lat%0d", i), ov_cyc[i], t0 + 2 * i + 9);
                check($sformatf("bub_d%0d", i), ov_dat[i], 8 * (i + 1));
            end
        end
        check("bub_l0_v0", lane(din_log[t0 + 1], 0), 1);
        check("bub_l0_gap", lane(din_log[t0 + 2], 0), 0);
        check("bub_l0_v1", lane(din_log[t0 + 3], 0), 2);
        check("bub_l7_v0", lane(din_log[t0 + 8], 7), 1);
        check("bub_l7_gap", lane(din_log[t0 + 9], 7), 0);
        check("bub_gate", gate_bad, 0);
        step();

        // Zero-length job
        clear_logs();
        in_valid = 1'b1; start = 1'b1; num_vec = 8'd0; w_in = {8{8'd9}};
        step();
        t0 = cyc;
        check("zero_we", we_rl, 1);
        start = 1'b0;
        wait_done(10);
        check("zero_done_cyc", done_cyc, t0 + 1);
        check("zero_rdy", rdy_cnt, 0);
        check("zero_ov", ov_cyc.size(), 0);
        in_valid = 1'b0;
        step();
        check("zero_busy", busy, 0);

        // Start held high while busy is ignored
        single_job("hold", {8{8'd3}}, {8{8'd2}}, 48, 1'b1);

        // Reset in the middle of a job
        clear_logs();
        start = 1'b1; num_vec = 8'd5; w_in = {8{8'd1}};
        step();
        start = 1'b0; in_valid = 1'b1; in_data = {8{8'd2}};
        step();
        step();
        step();
        check("mid_rdy_before", in_ready, 1);
        rstn = 1'b0;
        #1;
        check("mid_rdy", in_ready, 0);
        check("mid_busy", busy, 0);
        check("mid_din", din, 0);
        check("mid_w", weights, 0);
        check("mid_done", done, 0);
        in_valid = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
        check("mid_no_done", done_cnt, 0);
        single_job("after_rst", {8{8'd1}}, {8{8'd2}}, 16, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
